io_timer_bank: RTL and testbench

Memory-mapped bank of `CHANNELS` independent up-counting timers, each with reload, periodic or one-shot mode, and a per-channel interrupt enable. The bank sits on the IO page beside the UART and GPIO and is selected by one one-hot IO address bit. It drives a single level interrupt request into the processor's `interrupt_request` input. Register writes use the IO page's Write/Clear/Set/Toggle address modifiers.

---
 rtl/io_timer_bank.sv | 173 +++++++++++++++++
 tb/tb_io_timer_bank.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/io_timer_bank.sv
// Memory-mapped bank of up-counting timers with reload, one-shot mode and a level irq.
// Optional capture inputs are built only when TIMER_BANK_CAPTURE_EN is defined.
module io_timer_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sel,
    input  logic [9:0]          addr,
    input  logic                wr,
    input  logic                rd,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    input  logic [CHANNELS-1:0] cap_in,
    output logic                irq
);

    localparam logic [1:0] MOD_WRITE  = 2'd0;
    localparam logic [1:0] MOD_CLEAR  = 2'd1;
    localparam logic [1:0] MOD_SET    = 2'd2;
    localparam logic [1:0] MOD_TOGGLE = 2'd3;

    localparam logic [2:0] REG_COUNT   = 3'd0;
    localparam logic [2:0] REG_RELOAD  = 3'd1;
    localparam logic [2:0] REG_CTRL    = 3'd2;
    localparam logic [2:0] REG_PENDING = 3'd3;
    localparam logic [2:0] REG_CAPTURE = 3'd4;

    localparam logic [WIDTH-1:0] COUNT_MAX = '1;
`ifdef TIMER_BANK_CAPTURE_EN
    localparam logic [3:0] CTRL_MASK = 4'hF;
`else
    localparam logic [3:0] CTRL_MASK = 4'h7;
`endif

    logic [WIDTH-1:0]    count  [CHANNELS];
    logic [WIDTH-1:0]    reload [CHANNELS];
    logic [3:0]          ctrl   [CHANNELS];
    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] wrap;
    logic [CHANNELS-1:0] hw_set;
    logic [CHANNELS-1:0] ie_vec;

    logic [1:0]  mod;
    logic [2:0]  reg_idx;
    logic [2:0]  ch_idx;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] old_val;
    logic [31:0] new_val;

    assign mod     = addr[3:2];
    assign reg_idx = addr[6:4];
    assign ch_idx  = addr[9:7];
    assign wr_en   = sel & wr;
    assign rd_en   = sel & rd;

`ifdef TIMER_BANK_CAPTURE_EN
    logic [WIDTH-1:0]    capture [CHANNELS];
    logic [CHANNELS-1:0] cap_s1, cap_s2, cap_s3;
    logic [CHANNELS-1:0] cap_rise;
    assign cap_rise = cap_s2 & ~cap_s3;
    logic unused_bits;
    assign unused_bits = ^addr[1:0];
`else
    logic unused_bits;
    assign unused_bits = ^{addr[1:0], cap_in};
`endif

    // Current value of the addressed register; feeds both the read path and the modifiers.
    always_comb begin
        old_val = '0;
        if (reg_idx == REG_PENDING) begin
            old_val = 32'(pending);
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (ch_idx == 3'(i)) begin
                    case (reg_idx)
                        REG_COUNT:   old_val = 32'(count[i]);
                        REG_RELOAD:  old_val = 32'(reload[i]);
                        REG_CTRL:    old_val = 32'(ctrl[i]);
`ifdef TIMER_BANK_CAPTURE_EN
                        REG_CAPTURE: old_val = 32'(capture[i]);
`endif
                        default:     old_val = '0;
                    endcase
                end
            end
        end
    end

    always_comb begin
        new_val = wdata;
        case (mod)
            MOD_WRITE:  new_val = wdata;
            MOD_CLEAR:  new_val = old_val & ~wdata;
            MOD_SET:    new_val = old_val | wdata;
            MOD_TOGGLE: new_val = old_val ^ wdata;
            default:    new_val = wdata;
        endcase
    end

    always_comb begin
        wrap   = '0;
        hw_set = '0;
        ie_vec = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wrap[i]   = ctrl[i][0] && (count[i] == COUNT_MAX);
            ie_vec[i] = ctrl[i][2];
`ifdef TIMER_BANK_CAPTURE_EN
            hw_set[i] = wrap[i] | (cap_rise[i] & ctrl[i][3]);
`else
            hw_set[i] = wrap[i];
`endif
        end
    end

    assign irq = |(pending & ie_vec);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                count[i]  <= '0;
                reload[i] <= '0;
                ctrl[i]   <= '0;
`ifdef TIMER_BANK_CAPTURE_EN
                capture[i] <= '0;
`endif
            end
`ifdef TIMER_BANK_CAPTURE_EN
            cap_s1 <= '0;
            cap_s2 <= '0;
            cap_s3 <= '0;
`endif
            pending <= '0;
            rdata   <= '0;
        end else begin
            if (rd_en) rdata <= old_val;
            for (int i = 0; i < CHANNELS; i++) begin
                // Software writes win over reload/increment and over the one-shot EN clear.
                if (wr_en && ch_idx == 3'(i) && reg_idx == REG_COUNT)
                    count[i] <= new_val[WIDTH-1:0];
                else if (wrap[i])
                    count[i] <= reload[i];
                else if (ctrl[i][0])
                    count[i] <= count[i] + WIDTH'(1);

                if (wr_en && ch_idx == 3'(i) && reg_idx == REG_RELOAD)
                    reload[i] <= new_val[WIDTH-1:0];

                if (wr_en && ch_idx == 3'(i) && reg_idx == REG_CTRL)
                    ctrl[i] <= new_val[3:0] & CTRL_MASK;
                else if (wrap[i] && ctrl[i][1])
                    ctrl[i][0] <= 1'b0;
`ifdef TIMER_BANK_CAPTURE_EN
                if (cap_rise[i]) capture[i] <= count[i];
`endif
            end
`ifdef TIMER_BANK_CAPTURE_EN
            cap_s1 <= cap_in;
            cap_s2 <= cap_s1;
            cap_s3 <= cap_s2;
`endif
            // Hardware events are OR-ed in after the software update so a set beats a clear.
            if (wr_en && reg_idx == REG_PENDING)
                pending <= new_val[CHANNELS-1:0] | hw_set;
            else
                pending <= pending | hw_set;
        end
    end

endmodule

// File: tb/tb_io_timer_bank.sv
// Directed bench for io_timer_bank: reads go through an expected-value queue, checks are immediate assertions.
module tb_io_timer_bank;

    localparam int CH = 4;
    localparam int W  = 32;

    localparam logic [2:0] R_COUNT   = 3'd0;
    localparam logic [2:0] R_RELOAD  = 3'd1;
    localparam logic [2:0] R_CTRL    = 3'd2;
    localparam logic [2:0] R_PENDING = 3'd3;
    localparam logic [2:0] R_CAPTURE = 3'd4;

    localparam logic [1:0] M_WR  = 2'd0;
    localparam logic [1:0] M_CLR = 2'd1;
    localparam logic [1:0] M_SET = 2'd2;
    localparam logic [1:0] M_TGL = 2'd3;

    logic          clk = 1'b0;
    logic          reset;
    logic          sel;
    logic [9:0]    addr;
    logic          wr;
    logic          rd;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic [CH-1:0] cap_in;
    logic          irq;

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] exp_q[$];

    io_timer_bank #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .sel    (sel),
        .addr   (addr),
        .wr     (wr),
        .rd     (rd),
        .wdata  (wdata),
        .rdata  (rdata),
        .cap_in (cap_in),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] mk_addr(input logic [2:0] ch, input logic [2:0] rg, input logic [1:0] md);
        return {ch, rg, md, 2'b00};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Inputs change on the falling edge; the access lands on the following rising edge.
    task automatic bus_write(input logic [2:0] ch, input logic [2:0] rg, input logic [1:0] md,
                             input logic [31:0] data);
        sel = 1'b1; wr = 1'b1; addr = mk_addr(ch, rg, md); wdata = data;
        @(negedge clk);
        sel = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] ch, input logic [2:0] rg, input logic [31:0] exp,
                            input string tag);
        exp_q.push_back(exp);
        sel = 1'b1; rd = 1'b1; addr = mk_addr(ch, rg, M_WR);
        @(negedge clk);
        sel = 1'b0; rd = 1'b0;
        check(tag, rdata, exp_q.pop_front());
    endtask

    task automatic bus_wr_rd(input logic [2:0] ch, input logic [2:0] rg, input logic [1:0] md,
                             input logic [31:0] data, input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        sel = 1'b1; wr = 1'b1; rd = 1'b1; addr = mk_addr(ch, rg, md); wdata = data;
        @(negedge clk);
        sel = 1'b0; wr = 1'b0; rd = 1'b0;
        check(tag, rdata, exp_q.pop_front());
    endtask

    initial begin
        reset = 1'b1; sel = 1'b0; wr = 1'b0; rd = 1'b0;
        addr = '0; wdata = '0; cap_in = '0;
        tick(3);
        reset = 1'b0;
        check("reset_rdata", rdata, 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        for (int c = 0; c < 8; c++)
            for (int r = 0; r < 8; r++)
                bus_read(3'(c), 3'(r), 32'h0, $sformatf("reset_ch%0d_reg%0d", c, r));

        // Channel 0: four-cycle periodic timer with interrupt enabled.
        bus_write(3'd0, R_RELOAD, M_WR, 32'hFFFF_FFFC);
        bus_write(3'd0, R_COUNT,  M_WR, 32'hFFFF_FFFC);
        bus_write(3'd0, R_CTRL,   M_WR, 32'h5);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ch0_irq_low_%0d", i), 32'(irq), 32'h0);
            tick(1);
        end
        check("ch0_irq_wrap", 32'(irq), 32'h1);
        bus_read(3'd0, R_COUNT, 32'hFFFF_FFFC, "ch0_count_reloaded");
        bus_write(3'd0, R_PENDING, M_CLR, 32'h1);
        check("ch0_ack", 32'(irq), 32'h0);
        tick(2);
        check("ch0_period", 32'(irq), 32'h1);
        tick(3);
        bus_write(3'd0, R_PENDING, M_CLR, 32'h1);
        check("clear_vs_set", 32'(irq), 32'h1);
        bus_write(3'd0, R_PENDING, M_CLR, 32'h1);
        check("clear_nonwrap", 32'(irq), 32'h0);
        bus_write(3'd0, R_CTRL, M_WR, 32'h0);
        tick(2);
        bus_read(3'd0, R_COUNT, 32'hFFFF_FFFE, "ch0_hold");

        // Channel 1: one-shot.
        bus_write(3'd1, R_RELOAD, M_WR, 32'hFFFF_FFF0);
        bus_write(3'd1, R_COUNT,  M_WR, 32'hFFFF_FFFE);
        bus_write(3'd1, R_CTRL,   M_WR, 32'h7);
        check("ch1_irq_low0", 32'(irq), 32'h0);
        tick(1);
        check("ch1_irq_low1", 32'(irq), 32'h0);
        tick(1);
        check("ch1_irq_event", 32'(irq), 32'h1);
        bus_read(3'd1, R_CTRL, 32'h6, "ch1_en_cleared");
        tick(3);
        bus_read(3'd1, R_COUNT, 32'hFFFF_FFF0, "ch1_count_stays");
        bus_read(3'd1, R_PENDING, 32'h2, "ch1_pending");
        bus_write(3'd1, R_PENDING, M_CLR, 32'h2);
        check("ch1_ack", 32'(irq), 32'h0);

        // Bus corner cases.
        bus_wr_rd(3'd1, R_RELOAD, M_WR, 32'h1234_5678, 32'hFFFF_FFF0, "wr_rd_same_cycle");
        bus_read(3'd1, R_RELOAD, 32'h1234_5678, "reload_written");
        sel = 1'b0; wr = 1'b1; addr = mk_addr(3'd1, R_RELOAD, M_WR); wdata = 32'h0;
        @(negedge clk);
        wr = 1'b0;
        bus_read(3'd1, R_RELOAD, 32'h1234_5678, "unselected_write");
        bus_write(3'd1, R_RELOAD, M_TGL, 32'h0000_FFFF);
        bus_read(3'd1, R_RELOAD, 32'h1234_A987, "reload_toggle");
        bus_write(3'd1, R_RELOAD, M_CLR, 32'hF000_0000);
        bus_read(3'd1, R_RELOAD, 32'h0234_A987, "reload_clear");
        bus_write(3'd5, R_RELOAD, M_WR, 32'h0000_AAAA);
        bus_read(3'd5, R_RELOAD, 32'h0, "bad_channel");
        bus_write(3'd0, 3'd6, M_WR, 32'hFFFF_FFFF);
        bus_read(3'd0, 3'd6, 32'h0, "reserved_reg");

        // Channel 2: Set/Toggle on CTRL, COUNT write racing the wrap.
        bus_write(3'd2, R_COUNT, M_WR, 32'hFFFF_FFFD);
        bus_write(3'd2, R_CTRL, M_SET, 32'h4);
        bus_write(3'd2, R_CTRL, M_TGL, 32'h1);
        bus_read(3'd2, R_CTRL, 32'h5, "ch2_ctrl_set_toggle");
        tick(1);
        bus_write(3'd2, R_COUNT, M_WR, 32'h7);
        check("ch2_wrap_irq", 32'(irq), 32'h1);
        bus_read(3'd2, R_COUNT, 32'h7, "ch2_count_write_wins");
        bus_read(3'd2, R_COUNT, 32'h8, "ch2_count_runs");
        bus_read(3'd7, R_PENDING, 32'h4, "pending_any_channel");
        bus_write(3'd2, R_CTRL, M_WR, 32'h0);
        bus_write(3'd2, R_PENDING, M_CLR, 32'h4);
        check("ch2_ack", 32'(irq), 32'h0);

        // Channel 3: capture pulse while counting from 0x100.
        bus_write(3'd3, R_COUNT, M_WR, 32'h100);
        bus_write(3'd3, R_CTRL, M_WR, 32'h9);
        cap_in[3] = 1'b1;
        tick(3);
        cap_in = '0;
        check("ch3_irq_no_ie", 32'(irq), 32'h0);
`ifdef TIMER_BANK_CAPTURE_EN
        bus_read(3'd3, R_PENDING, 32'h8, "cap_pending");
        bus_read(3'd3, R_CAPTURE, 32'h102, "cap_value");
        bus_read(3'd3, R_CTRL, 32'h9, "cap_ctrl");
`else
        bus_read(3'd3, R_PENDING, 32'h0, "cap_pending");
        bus_read(3'd3, R_CAPTURE, 32'h0, "cap_value");
        bus_read(3'd3, R_CTRL, 32'h1, "cap_ctrl");
`endif

        // Reset while channel 3 is running.
        bus_write(3'd3, R_CTRL, M_SET, 32'h4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("midrun_reset_irq", 32'(irq), 32'h0);
        check("midrun_reset_rdata", rdata, 32'h0);
        bus_read(3'd3, R_COUNT, 32'h0, "midrun_reset_count");
        bus_read(3'd3, R_CTRL, 32'h0, "midrun_reset_ctrl");
        bus_read(3'd0, R_PENDING, 32'h0, "midrun_reset_pending");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
